// File: rtl/uart_core.sv
// uart_core: full-duplex UART with independent TX/RX engines.
// Per-bit clock divider, optional parity, 1 or 2 stop bits.
module uart_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = 4;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);
    localparam logic             PAR_ON    = (PARITY_EN != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [DIV_W-1:0]     tx_div;
    logic [CNT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic                 tx_end;

    assign tx_ready = (tx_state == S_IDLE);
    assign tx_end   = (tx_div == DIV_MAX);

    // TX frame sequencer: one bit per divider wrap, line driven from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            if (tx_state != S_IDLE) begin
                tx_div <= tx_end ? '0 : tx_div + 1'b1;
            end
            case (tx_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        tx_shreg <= tx_data;
                        tx_par   <= (^tx_data) ^ ODD;
                        tx       <= 1'b0;
                        tx_div   <= '0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_end) begin
                        tx       <= tx_shreg[0];
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_end) begin
                        if (tx_bit == DATA_LAST) begin
                            tx_bit <= '0;
                            if (PAR_ON) begin
                                tx       <= tx_par;
                                tx_state <= S_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                tx_state <= S_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shreg <= {1'b0, tx_shreg[DATA_BITS-1:1]};
                            tx       <= tx_shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_end) begin
                        tx       <= 1'b1;
                        tx_bit   <= '0;
                        tx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tx_end) begin
                        if (tx_bit == STOP_LAST) begin
                            tx_state <= S_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    tx_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_q;
    logic                 rx_fall;
    logic [2:0]           rx_state;
    logic [DIV_W-1:0]     rx_div;
    logic [CNT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_par;
    logic                 rx_ferr;
    logic                 rx_end;

    assign rx_fall = rx_q & ~rx_s2;
    assign rx_end  = (rx_div == DIV_MAX);

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    // RX frame sequencer: mid-bit sampling, result latched after last stop
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= S_IDLE;
            rx_div        <= '0;
            rx_bit        <= '0;
            rx_shreg      <= '0;
            rx_par        <= 1'b0;
            rx_ferr       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_div   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_div == DIV_HALF) begin
                        rx_div  <= '0;
                        rx_bit  <= '0;
                        rx_ferr <= 1'b0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_div <= rx_div + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_end) begin
                        rx_div   <= '0;
                        rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_bit   <= '0;
                            rx_state <= PAR_ON ? S_PARITY : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_div <= rx_div + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_end) begin
                        rx_div   <= '0;
                        rx_par   <= rx_s2;
                        rx_bit   <= '0;
                        rx_state <= S_STOP;
                    end else begin
                        rx_div <= rx_div + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_end) begin
                        rx_div <= '0;
                        if (!rx_s2) begin
                            rx_ferr <= 1'b1;
                        end
                        if (rx_bit == STOP_LAST) begin
                            rx_data       <= rx_shreg;
                            rx_parity_err <= PAR_ON &&
                                (rx_par != ((^rx_shreg) ^ ODD));
                            rx_frame_err  <= rx_ferr | ~rx_s2;
                            rx_valid      <= 1'b1;
                            rx_state      <= S_IDLE;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_div <= rx_div + 1'b1;
                    end
                end
                default: begin
                    rx_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
